// File: rtl/queue_event_ctrl_if.sv
// queue_event_ctrl_if: raw bank-queue buttons in, dispatch pulses and status out.
// master drives buttons/tcount; slave (the controller) drives the rest.
interface queue_event_ctrl_if #(
  parameter int N_TELLERS = 3,
  parameter int TICKET_W  = 4
);

  logic                 arrive_btn;
  logic [N_TELLERS-1:0] next_btn;
  logic [1:0]           tcount;
  logic                 up;
  logic                 down;
  logic [2:0]           occupancy;
  logic [TICKET_W-1:0]  ticket_issued;
  logic [TICKET_W-1:0]  serving_ticket;
  logic [1:0]           serving_teller;
  logic                 reject;
  logic                 idle_call;

  modport master (
    output arrive_btn,
    output next_btn,
    output tcount,
    input  up,
    input  down,
    input  occupancy,
    input  ticket_issued,
    input  serving_ticket,
    input  serving_teller,
    input  reject,
    input  idle_call
  );

  modport slave (
    input  arrive_btn,
    input  next_btn,
    input  tcount,
    output up,
    output down,
    output occupancy,
    output ticket_issued,
    output serving_ticket,
    output serving_teller,
    output reject,
    output idle_call
  );

endinterface

// File: rtl/queue_event_ctrl.sv
// queue_event_ctrl: sync/debounce/edge-detect buttons, arbitrate, emit up/down.
// Ports: clk, reset (sync, active high), bus (slave: buttons in, pulses/status out).
module queue_event_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int N_TELLERS       = 3,
  parameter int TICKET_W        = 4,
  parameter int DEPTH           = 7
) (
  input logic               clk,
  input logic               reset,
  queue_event_ctrl_if.slave bus
);

  // button index N_TELLERS is the arrival button
  localparam int NB = N_TELLERS + 1;
  localparam int SW = $clog2(NB);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_GAP
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [NB-1:0] w_raw;
  logic [NB-1:0] r_s1;
  logic [NB-1:0] r_s2;
  logic [NB-1:0] r_deb;
  logic [NB-1:0] r_deb_q;
  logic [CW-1:0] r_cnt [NB];
  logic [NB-1:0] r_pend;
  logic [NB-1:0] w_rise;
  logic [NB-1:0] w_clr;

  logic [SW-1:0] r_sel;
  logic [SW-1:0] r_last;
  logic [1:0]    r_skip;
  logic [SW-1:0] w_sel;
  logic [SW-1:0] w_idx;
  logic          w_sel_vld;

  logic [1:0]    w_tc;
  logic [NB-1:0] w_active;
  logic          w_is_arr;
  logic          w_full;
  logic          w_empty;

  logic          w_up;
  logic          w_down;
  logic          w_rej;
  logic          w_idle;

  logic                r_up;
  logic                r_down;
  logic                r_rej;
  logic                r_idle;
  logic [2:0]          r_occ;
  logic [TICKET_W-1:0] r_tiss;
  logic [TICKET_W-1:0] r_tsrv;
  logic [1:0]          r_steller;

  assign w_raw = {bus.arrive_btn, bus.next_btn};

  // input conditioning
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1    <= '0;
      r_s2    <= '0;
      r_deb   <= '0;
      r_deb_q <= '0;
      for (int b = 0; b < NB; b++) begin
        r_cnt[b] <= '0;
      end
    end else begin
      r_s1    <= w_raw;
      r_s2    <= r_s1;
      r_deb_q <= r_deb;
      for (int b = 0; b < NB; b++) begin
        if (r_s2[b] == r_deb[b]) begin
          r_cnt[b] <= '0;
        end else if (r_cnt[b] == CW'(DEBOUNCE_CYCLES - 1)) begin
          r_deb[b] <= r_s2[b];
          r_cnt[b] <= '0;
        end else begin
          r_cnt[b] <= r_cnt[b] + CW'(1);
        end
      end
    end
  end

  assign w_rise = r_deb & ~r_deb_q;

  // an edge on the button being granted merges into that grant
  assign w_clr = (r_state == S_GRANT) ? (NB'(1) << r_sel) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend <= '0;
    end else begin
      r_pend <= (r_pend | w_rise) & ~w_clr;
    end
  end

  // arbitration: round-robin tellers, arrival only when no call,
  // unless arrival has already been passed over twice
  always_comb begin
    w_sel_vld = 1'b0;
    w_sel     = '0;
    w_idx     = '0;
    for (int i = 1; i <= N_TELLERS; i++) begin
      w_idx = SW'((int'(r_last) + i) % N_TELLERS);
      if (!w_sel_vld && r_pend[w_idx]) begin
        w_sel_vld = 1'b1;
        w_sel     = w_idx;
      end
    end
    if (r_pend[N_TELLERS] && (!w_sel_vld || r_skip == 2'd2)) begin
      w_sel_vld = 1'b1;
      w_sel     = SW'(N_TELLERS);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sel  <= '0;
      r_last <= SW'(N_TELLERS - 1);
      r_skip <= '0;
    end else if (r_state == S_IDLE && w_sel_vld) begin
      r_sel <= w_sel;
      if (w_sel == SW'(N_TELLERS)) begin
        r_skip <= '0;
      end else begin
        r_last <= w_sel;
        if (r_pend[N_TELLERS] && r_skip != 2'd2) begin
          r_skip <= r_skip + 2'd1;
        end
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_sel_vld) w_state_nxt = S_GRANT;
      S_GRANT: w_state_nxt = S_GAP;
      S_GAP:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // teller i+1 active iff i < tcount, tcount 0 read as 1
  assign w_tc = (bus.tcount == 2'd0) ? 2'd1 : bus.tcount;

  always_comb begin
    w_active = '0;
    for (int i = 0; i < N_TELLERS; i++) begin
      w_active[i] = (i < int'(w_tc));
    end
  end

  assign w_is_arr = (r_sel == SW'(N_TELLERS));
  assign w_full   = (r_occ == 3'(DEPTH));
  assign w_empty  = (r_occ == 3'd0);

  // FSM outputs: exactly one action in GRANT
  always_comb begin
    w_up   = 1'b0;
    w_down = 1'b0;
    w_rej  = 1'b0;
    w_idle = 1'b0;
    if (r_state == S_GRANT) begin
      unique case (1'b1)
        w_is_arr && w_full:                    w_rej  = 1'b1;
        w_is_arr && !w_full:                   w_up   = 1'b1;
        !w_is_arr && w_active[r_sel] && w_empty:  w_idle = 1'b1;
        !w_is_arr && w_active[r_sel] && !w_empty: w_down = 1'b1;
        default: ;
      endcase
    end
  end

  // registered outputs and queue/ticket state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_up      <= 1'b0;
      r_down    <= 1'b0;
      r_rej     <= 1'b0;
      r_idle    <= 1'b0;
      r_occ     <= '0;
      r_tiss    <= '0;
      r_tsrv    <= '0;
      r_steller <= '0;
    end else begin
      r_up   <= w_up;
      r_down <= w_down;
      r_rej  <= w_rej;
      r_idle <= w_idle;
      if (w_up) begin
        r_occ  <= r_occ + 3'd1;
        r_tiss <= r_tiss + TICKET_W'(1);
      end
      if (w_down) begin
        r_occ     <= r_occ - 3'd1;
        r_tsrv    <= r_tsrv + TICKET_W'(1);
        r_steller <= 2'(r_sel) + 2'd1;
      end
    end
  end

  assign bus.up             = r_up;
  assign bus.down           = r_down;
  assign bus.reject         = r_rej;
  assign bus.idle_call      = r_idle;
  assign bus.occupancy      = r_occ;
  assign bus.ticket_issued  = r_tiss;
  assign bus.serving_ticket = r_tsrv;
  assign bus.serving_teller = r_steller;

endmodule

// File: tb/tb_queue_event_ctrl.sv
// tb_queue_event_ctrl: directed scenarios plus randomized single-button
// traffic checked against a transaction-level queue/ticket model.
module tb_queue_event_ctrl;

  logic clk;
  logic reset;

  queue_event_ctrl_if #(.N_TELLERS(3), .TICKET_W(4)) bus ();

  queue_event_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .N_TELLERS(3),
    .TICKET_W(4),
    .DEPTH(7)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  int tests;
  int fails;
  int n_up;
  int n_down;
  int n_rej;
  int n_idle;
  int evlog[$];
  logic prev_act;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // monitor: pulse counting, event log, invariants
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      tests++;
      if ((bus.up === 1'b1 && bus.down === 1'b1) || bus.occupancy > 3'd7 ||
          (prev_act && (bus.up === 1'b1 || bus.down === 1'b1))) begin
        fails++;
        $display("FAIL invariant: up=%0b down=%0b occ=%0d prev_act=%0b, need exclusive gapped pulses, occ<=7",
                 bus.up, bus.down, bus.occupancy, prev_act);
      end
    end
    prev_act = !reset && (bus.up === 1'b1 || bus.down === 1'b1);
    if (bus.up === 1'b1) begin n_up++; evlog.push_back(4); end
    if (bus.down === 1'b1) begin n_down++; evlog.push_back(8 + int'(bus.serving_teller)); end
    if (bus.reject === 1'b1) begin n_rej++; evlog.push_back(12); end
    if (bus.idle_call === 1'b1) begin n_idle++; evlog.push_back(16); end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic press(input logic a, input logic [2:0] n, input int hold, input int gap);
    bus.arrive_btn = a;
    bus.next_btn   = n;
    repeat (hold) tick();
    bus.arrive_btn = 1'b0;
    bus.next_btn   = 3'b000;
    repeat (gap) tick();
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.arrive_btn = 1'b1;
    tick();
    tests++;
    if ({bus.up, bus.down, bus.reject, bus.idle_call, bus.occupancy,
         bus.ticket_issued, bus.serving_ticket, bus.serving_teller} !== 17'd0) begin
      fails++;
      $display("FAIL reset_outputs: got up=%0b down=%0b occ=%0d tiss=%0d tsrv=%0d stel=%0d, need all 0",
               bus.up, bus.down, bus.occupancy, bus.ticket_issued, bus.serving_ticket, bus.serving_teller);
    end
    bus.arrive_btn = 1'b0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_latency;
    int u0;
    do_reset();
    u0 = n_up;
    bus.arrive_btn = 1'b1;
    for (int k = 0; k <= 24; k++) begin
      tick();
      if (k == 9) bus.arrive_btn = 1'b0;
      tests++;
      if (bus.up !== (k == 8)) begin
        fails++;
        $display("FAIL latency_up k=%0d: got %0b need %0b", k, bus.up, (k == 8));
      end
    end
    tests++;
    if (n_up - u0 !== 1 || bus.ticket_issued !== 4'd1 || bus.occupancy !== 3'd1) begin
      fails++;
      $display("FAIL latency_state: ups=%0d tiss=%0d occ=%0d, need 1/1/1",
               n_up - u0, bus.ticket_issued, bus.occupancy);
    end
  endtask

  task automatic test_glitch;
    int tot;
    do_reset();
    tot = n_up + n_down + n_rej + n_idle;
    press(1'b1, 3'b000, 3, 20);
    press(1'b0, 3'b011, 3, 20);
    tests++;
    if (n_up + n_down + n_rej + n_idle !== tot || bus.occupancy !== 3'd0 ||
        bus.ticket_issued !== 4'd0) begin
      fails++;
      $display("FAIL glitch: events=%0d occ=%0d tiss=%0d, need 0/0/0",
               n_up + n_down + n_rej + n_idle - tot, bus.occupancy, bus.ticket_issued);
    end
  endtask

  task automatic test_fill;
    int u0;
    int r0;
    do_reset();
    u0 = n_up;
    r0 = n_rej;
    for (int i = 0; i < 7; i++) press(1'b1, 3'b000, 8, 16);
    tests++;
    if (n_up - u0 !== 7 || bus.occupancy !== 3'd7 || bus.ticket_issued !== 4'd7) begin
      fails++;
      $display("FAIL fill: ups=%0d occ=%0d tiss=%0d, need 7/7/7",
               n_up - u0, bus.occupancy, bus.ticket_issued);
    end
    press(1'b1, 3'b000, 8, 16);
    tests++;
    if (n_rej - r0 !== 1 || n_up - u0 !== 7 || bus.occupancy !== 3'd7 ||
        bus.ticket_issued !== 4'd7) begin
      fails++;
      $display("FAIL full_reject: rej=%0d ups=%0d occ=%0d tiss=%0d, need 1/7/7/7",
               n_rej - r0, n_up - u0, bus.occupancy, bus.ticket_issued);
    end
  endtask

  task automatic test_multi_call;
    do_reset();
    bus.tcount = 2'd2;
    for (int i = 0; i < 3; i++) press(1'b1, 3'b000, 8, 16);
    evlog.delete();
    press(1'b0, 3'b111, 8, 30);
    tests++;
    if (evlog.size() != 2 || evlog[0] != 9 || evlog[1] != 10) begin
      fails++;
      $display("FAIL multi_call_order: got %0d events %p, need down t1 then down t2", evlog.size(), evlog);
    end
    tests++;
    if (bus.occupancy !== 3'd1 || bus.serving_ticket !== 4'd2 || bus.serving_teller !== 2'd2) begin
      fails++;
      $display("FAIL multi_call_state: occ=%0d tsrv=%0d stel=%0d, need 1/2/2",
               bus.occupancy, bus.serving_ticket, bus.serving_teller);
    end
  endtask

  task automatic test_arrive_vs_call;
    do_reset();
    bus.tcount = 2'd1;
    press(1'b1, 3'b000, 8, 16);
    press(1'b1, 3'b000, 8, 16);
    evlog.delete();
    press(1'b1, 3'b001, 8, 30);
    tests++;
    if (evlog.size() != 2 || evlog[0] != 9 || evlog[1] != 4 || bus.occupancy !== 3'd2) begin
      fails++;
      $display("FAIL arrive_vs_call: events %p occ=%0d, need down t1, up, occ 2", evlog, bus.occupancy);
    end
  endtask

  task automatic test_starvation;
    do_reset();
    bus.tcount = 2'd3;
    for (int i = 0; i < 5; i++) press(1'b1, 3'b000, 8, 16);
    evlog.delete();
    press(1'b1, 3'b111, 8, 40);
    tests++;
    if (evlog.size() != 4 || evlog[0] != 9 || evlog[1] != 10 || evlog[2] != 4 || evlog[3] != 11) begin
      fails++;
      $display("FAIL starvation_order: got %p, need t1,t2,arrival,t3", evlog);
    end
    tests++;
    if (bus.occupancy !== 3'd3 || bus.ticket_issued !== 4'd6 || bus.serving_ticket !== 4'd3) begin
      fails++;
      $display("FAIL starvation_state: occ=%0d tiss=%0d tsrv=%0d, need 3/6/3",
               bus.occupancy, bus.ticket_issued, bus.serving_ticket);
    end
  endtask

  task automatic test_idle_wrap;
    int i0;
    do_reset();
    bus.tcount = 2'd1;
    i0 = n_idle;
    press(1'b0, 3'b001, 8, 16);
    tests++;
    if (n_idle - i0 !== 1 || bus.serving_ticket !== 4'd0 || bus.serving_teller !== 2'd0) begin
      fails++;
      $display("FAIL idle_call: idles=%0d tsrv=%0d stel=%0d, need 1/0/0",
               n_idle - i0, bus.serving_ticket, bus.serving_teller);
    end
    for (int i = 0; i < 17; i++) begin
      press(1'b1, 3'b000, 8, 16);
      tests++;
      if (bus.ticket_issued !== 4'((i + 1) % 16) || bus.occupancy !== 3'd1) begin
        fails++;
        $display("FAIL wrap_issue i=%0d: tiss=%0d occ=%0d, need %0d/1",
                 i, bus.ticket_issued, bus.occupancy, (i + 1) % 16);
      end
      press(1'b0, 3'b001, 8, 16);
      tests++;
      if (bus.serving_ticket !== 4'((i + 1) % 16) || bus.occupancy !== 3'd0 ||
          bus.serving_teller !== 2'd1) begin
        fails++;
        $display("FAIL wrap_serve i=%0d: tsrv=%0d occ=%0d stel=%0d, need %0d/0/1",
                 i, bus.serving_ticket, bus.occupancy, bus.serving_teller, (i + 1) % 16);
      end
    end
  endtask

  task automatic test_reset_in_grant;
    int u0;
    do_reset();
    bus.arrive_btn = 1'b1;
    for (int k = 0; k <= 7; k++) tick();
    bus.arrive_btn = 1'b0;
    reset = 1'b1;
    tick();
    tests++;
    if ({bus.up, bus.down, bus.reject, bus.idle_call, bus.occupancy,
         bus.ticket_issued, bus.serving_ticket, bus.serving_teller} !== 17'd0) begin
      fails++;
      $display("FAIL reset_in_grant: up=%0b occ=%0d tiss=%0d, need all 0",
               bus.up, bus.occupancy, bus.ticket_issued);
    end
    reset = 1'b0;
    u0 = n_up;
    repeat (25) tick();
    tests++;
    if (n_up - u0 !== 0 || bus.occupancy !== 3'd0) begin
      fails++;
      $display("FAIL reset_abort: ups=%0d occ=%0d, need 0/0", n_up - u0, bus.occupancy);
    end
  endtask

  task automatic test_random;
    int m_occ;
    int m_tiss;
    int m_tsrv;
    int m_stel;
    int e_up;
    int e_down;
    int e_rej;
    int e_idle;
    int tc;
    int t;
    int u0;
    int d0;
    int r0;
    int i0;
    do_reset();
    m_occ = 0; m_tiss = 0; m_tsrv = 0; m_stel = 0;
    e_up = 0; e_down = 0; e_rej = 0; e_idle = 0;
    u0 = n_up; d0 = n_down; r0 = n_rej; i0 = n_idle;
    for (int it = 0; it < 40; it++) begin
      tc = $urandom_range(0, 3);
      bus.tcount = 2'(tc);
      if (tc == 0) tc = 1;
      if ($urandom_range(0, 9) < 6) begin
        press(1'b1, 3'b000, $urandom_range(6, 10), 16);
        if (m_occ == 7) e_rej++;
        else begin m_occ++; m_tiss = (m_tiss + 1) % 16; e_up++; end
      end else begin
        t = $urandom_range(0, 2);
        press(1'b0, 3'(1 << t), $urandom_range(6, 10), 16);
        if (t < tc) begin
          if (m_occ == 0) e_idle++;
          else begin m_occ--; m_tsrv = (m_tsrv + 1) % 16; m_stel = t + 1; e_down++; end
        end
      end
      tests++;
      if (bus.occupancy !== 3'(m_occ) || bus.ticket_issued !== 4'(m_tiss) ||
          bus.serving_ticket !== 4'(m_tsrv) || bus.serving_teller !== 2'(m_stel)) begin
        fails++;
        $display("FAIL random_state it=%0d: occ=%0d tiss=%0d tsrv=%0d stel=%0d, need %0d/%0d/%0d/%0d",
                 it, bus.occupancy, bus.ticket_issued, bus.serving_ticket, bus.serving_teller,
                 m_occ, m_tiss, m_tsrv, m_stel);
      end
      tests++;
      if (n_up - u0 != e_up || n_down - d0 != e_down || n_rej - r0 != e_rej || n_idle - i0 != e_idle) begin
        fails++;
        $display("FAIL random_events it=%0d: up/down/rej/idle=%0d/%0d/%0d/%0d need %0d/%0d/%0d/%0d",
                 it, n_up - u0, n_down - d0, n_rej - r0, n_idle - i0, e_up, e_down, e_rej, e_idle);
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    n_up = 0;
    n_down = 0;
    n_rej = 0;
    n_idle = 0;
    prev_act = 1'b0;
    reset = 1'b1;
    bus.arrive_btn = 1'b0;
    bus.next_btn = 3'b000;
    bus.tcount = 2'd3;
    test_reset();
    test_latency();
    test_glitch();
    test_fill();
    test_multi_call();
    test_arrive_vs_call();
    test_starvation();
    test_idle_wrap();
    test_reset_in_grant();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
